// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-port
// synchronous RAM with registered read. Each requester issues one read or
// write command through a req/gnt handshake. Commands are serialized onto
// the RAM pins. Read data goes back to the requester that issued the read,
// together with a one-cycle rvalid strobe.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req0/we0/addr0/wdata0      requester 0 command (held until gnt0)
//   gnt0                       requester 0 command issued (1-cycle pulse)
//   rvalid0/rdata0             requester 0 read return (data held)
//   req1 ... rdata1            same for requester 1
//   ram_rd/ram_wr              RAM strobes, high only in the ISSUE cycle
//   ram_addr/ram_din           RAM address / write data
//   ram_dout                   RAM read data, valid RD_LAT cycles after ram_rd
module ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic              cmd_we;
    logic              cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              ptr;
    logic [2:0]        cnt;
    logic              winner;
    logic              capture;

    // With both requesters active the pointer decides; otherwise the single
    // active one wins (req1 alone selects 1, req0 alone selects 0).
    always_comb begin
        winner = (req0 && req1) ? ptr : req1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-cycle strobes. capture marks the WAIT
    // cycle in which ram_dout carries the read data.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                gnt0       = ~cmd_id;
                gnt1       = cmd_id;
                ram_wr     = cmd_we;
                ram_rd     = ~cmd_we;
                state_next = cmd_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command registers, round-robin pointer, latency counter and read
    // return. The command registers only change when a new command is
    // accepted, so they also serve as the held RAM address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            ptr       <= 1'b0;
            cnt       <= 3'd0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            rvalid0 <= capture & ~cmd_id;
            rvalid1 <= capture & cmd_id;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        cmd_id    <= winner;
                        cmd_we    <= winner ? we1 : we0;
                        cmd_addr  <= winner ? addr1 : addr0;
                        cmd_wdata <= winner ? wdata1 : wdata0;
                    end
                end
                ISSUE: begin
                    ptr <= ~cmd_id;
                    cnt <= 3'(RD_LAT);
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                end
                default: begin
                end
            endcase
            if (capture) begin
                if (cmd_id) begin
                    rdata1 <= ram_dout;
                end else begin
                    rdata0 <= ram_dout;
                end
            end
        end
    end

    assign ram_addr = cmd_addr;
    assign ram_din  = cmd_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed self-checking bench for ram_arbiter. Instance "a" uses RD_LAT=1
// and instance "b" uses RD_LAT=3. Each instance has its own behavioural RAM
// model. Read data from the model is present only in the exact cycle it is
// due, so latency errors in the arbiter show up as wrong data.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_rd, ram_wr;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    logic       b_req0, b_we0, b_req1, b_we1;
    logic [3:0] b_addr0, b_addr1;
    logic [7:0] b_wdata0, b_wdata1;
    logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [7:0] b_rdata0, b_rdata1;
    logic       b_ram_rd, b_ram_wr;
    logic [3:0] b_ram_addr;
    logic [7:0] b_ram_din, b_ram_dout;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] b_p1, b_p2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_arbiter #(.DATA_W(8), .ADDR_W(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr),
        .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // RAM with a single-cycle registered read.
    always @(posedge clk) begin
        if (ram_wr) mem_a[ram_addr] <= ram_din;
        ram_dout <= ram_rd ? mem_a[ram_addr] : 8'h00;
    end

    // RAM with a three-cycle read pipeline.
    always @(posedge clk) begin
        if (b_ram_wr) mem_b[b_ram_addr] <= b_ram_din;
        b_p1       <= b_ram_rd ? mem_b[b_ram_addr] : 8'h00;
        b_p2       <= b_p1;
        b_ram_dout <= b_p2;
    end

    // Advance one cycle. Sampling and driving happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_rd, ram_wr, ram_addr, ram_din, rdata0, rdata1} !== 38'd0)
            begin tests_failed++; $display("[TB] FAIL reset_outputs_a: got %h required 0", {gnt0, gnt1, rvalid0, rvalid1, ram_rd, ram_wr, ram_addr, ram_din, rdata0, rdata1}); end
        tests_run++;
        if ({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_ram_rd, b_ram_wr, b_ram_addr, b_ram_din, b_rdata0, b_rdata1} !== 38'd0)
            begin tests_failed++; $display("[TB] FAIL reset_outputs_b: got %h required 0", {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_ram_rd, b_ram_wr, b_ram_addr, b_ram_din, b_rdata0, b_rdata1}); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_rd, ram_wr} !== 6'd0)
            begin tests_failed++; $display("[TB] FAIL reset_release_idle: got %b required 000000", {gnt0, gnt1, rvalid0, rvalid1, ram_rd, ram_wr}); end
    endtask

    task automatic test_write_read_r0();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 8'hCA;
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_wr, ram_rd, ram_addr, ram_din} !== {4'b1010, 4'd2, 8'hCA})
            begin tests_failed++; $display("[TB] FAIL wr0_issue: got %h required %h", {gnt0, gnt1, ram_wr, ram_rd, ram_addr, ram_din}, {4'b1010, 4'd2, 8'hCA}); end
        we0 = 1'b0;
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_wr, ram_rd} !== 4'b0000)
            begin tests_failed++; $display("[TB] FAIL wr0_back_idle: got %b required 0000", {gnt0, gnt1, ram_wr, ram_rd}); end
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_wr, ram_rd, ram_addr} !== {4'b1001, 4'd2})
            begin tests_failed++; $display("[TB] FAIL rd0_issue: got %h required %h", {gnt0, gnt1, ram_wr, ram_rd, ram_addr}, {4'b1001, 4'd2}); end
        req0 = 1'b0;
        tick();
        tests_run++;
        if ({gnt0, rvalid0, rvalid1} !== 3'b000)
            begin tests_failed++; $display("[TB] FAIL rd0_wait: got %b required 000", {gnt0, rvalid0, rvalid1}); end
        tick();
        tests_run++;
        if ({rvalid0, rvalid1, gnt1, rdata0} !== {3'b100, 8'hCA})
            begin tests_failed++; $display("[TB] FAIL rd0_return: got %h required %h", {rvalid0, rvalid1, gnt1, rdata0}, {3'b100, 8'hCA}); end
        tick();
        tests_run++;
        if ({rvalid0, rdata0} !== {1'b0, 8'hCA})
            begin tests_failed++; $display("[TB] FAIL rd0_hold: got %h required %h", {rvalid0, rdata0}, {1'b0, 8'hCA}); end
    endtask

    task automatic test_cross_requester();
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; wdata1 = 8'hAB;
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_wr, ram_rd, ram_addr, ram_din} !== {4'b0110, 4'd5, 8'hAB})
            begin tests_failed++; $display("[TB] FAIL wr1_issue: got %h required %h", {gnt0, gnt1, ram_wr, ram_rd, ram_addr, ram_din}, {4'b0110, 4'd5, 8'hAB}); end
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
        tick();
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_rd, ram_addr} !== {3'b101, 4'd5})
            begin tests_failed++; $display("[TB] FAIL xrd0_issue: got %h required %h", {gnt0, gnt1, ram_rd, ram_addr}, {3'b101, 4'd5}); end
        req0 = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b10, 8'hAB, 8'h00})
            begin tests_failed++; $display("[TB] FAIL xrd0_return: got %h required %h", {rvalid0, rvalid1, rdata0, rdata1}, {2'b10, 8'hAB, 8'h00}); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 8'h33;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 4'd1 : 4'd3;
            exp_data = (i % 2 == 0) ? 8'h11 : 8'h33;
            tick();
            tests_run++;
            if ({gnt0, gnt1, ram_wr, ram_addr, ram_din} !== {(i % 2 == 0), (i % 2 == 1), 1'b1, exp_addr, exp_data})
                begin tests_failed++; $display("[TB] FAIL sim_grant%0d: got %h required %h", i, {gnt0, gnt1, ram_wr, ram_addr, ram_din}, {(i % 2 == 0), (i % 2 == 1), 1'b1, exp_addr, exp_data}); end
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
            end
            tick();
            tests_run++;
            if ({gnt0, gnt1, ram_wr} !== 3'b000)
                begin tests_failed++; $display("[TB] FAIL sim_gap%0d: got %b required 000", i, {gnt0, gnt1, ram_wr}); end
        end
        tests_run++;
        if ({mem_a[1], mem_a[3]} !== 16'h1133)
            begin tests_failed++; $display("[TB] FAIL sim_ram_contents: got %h required 1133", {mem_a[1], mem_a[3]}); end
    endtask

    task automatic test_read_interleave();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_rd, ram_addr} !== {3'b101, 4'd1})
            begin tests_failed++; $display("[TB] FAIL il_issue0: got %h required %h", {gnt0, gnt1, ram_rd, ram_addr}, {3'b101, 4'd1}); end
        req0 = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({rvalid0, rvalid1, rdata0} !== {2'b10, 8'h11})
            begin tests_failed++; $display("[TB] FAIL il_return0: got %h required %h", {rvalid0, rvalid1, rdata0}, {2'b10, 8'h11}); end
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_rd, ram_addr} !== {3'b011, 4'd3})
            begin tests_failed++; $display("[TB] FAIL il_issue1: got %h required %h", {gnt0, gnt1, ram_rd, ram_addr}, {3'b011, 4'd3}); end
        req1 = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== {2'b01, 8'h11, 8'h33})
            begin tests_failed++; $display("[TB] FAIL il_return1: got %h required %h", {rvalid0, rvalid1, rdata0, rdata1}, {2'b01, 8'h11, 8'h33}); end
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
        tick();
        req0 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_rd, ram_wr, ram_addr, ram_din, rdata0, rdata1} !== 38'd0)
            begin tests_failed++; $display("[TB] FAIL midrd_reset_outputs: got %h required 0", {gnt0, gnt1, rvalid0, rvalid1, ram_rd, ram_wr, ram_addr, ram_din, rdata0, rdata1}); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0000)
                begin tests_failed++; $display("[TB] FAIL midrd_no_rvalid%0d: got %b required 0000", i, {rvalid0, rvalid1, gnt0, gnt1}); end
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 8'h77;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd8; wdata1 = 8'h88;
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_addr, ram_din} !== {2'b10, 4'd7, 8'h77})
            begin tests_failed++; $display("[TB] FAIL midrd_ptr_reset: got %h required %h", {gnt0, gnt1, ram_addr, ram_din}, {2'b10, 4'd7, 8'h77}); end
        req0 = 1'b0; we0 = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({gnt0, gnt1, ram_addr, ram_din} !== {2'b01, 4'd8, 8'h88})
            begin tests_failed++; $display("[TB] FAIL midrd_second_grant: got %h required %h", {gnt0, gnt1, ram_addr, ram_din}, {2'b01, 4'd8, 8'h88}); end
        req1 = 1'b0; we1 = 1'b0;
        tick();
    endtask

    task automatic test_rd_lat3();
        b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 4'd4; b_wdata0 = 8'h5A;
        tick();
        tests_run++;
        if ({b_gnt0, b_ram_wr, b_ram_addr, b_ram_din} !== {2'b11, 4'd4, 8'h5A})
            begin tests_failed++; $display("[TB] FAIL lat3_write: got %h required %h", {b_gnt0, b_ram_wr, b_ram_addr, b_ram_din}, {2'b11, 4'd4, 8'h5A}); end
        b_we0 = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({b_gnt0, b_ram_rd, b_ram_addr} !== {2'b11, 4'd4})
            begin tests_failed++; $display("[TB] FAIL lat3_read_issue: got %h required %h", {b_gnt0, b_ram_rd, b_ram_addr}, {2'b11, 4'd4}); end
        b_req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({b_rvalid0, b_gnt0, b_ram_rd} !== 3'b000)
                begin tests_failed++; $display("[TB] FAIL lat3_wait%0d: got %b required 000", i, {b_rvalid0, b_gnt0, b_ram_rd}); end
        end
        tick();
        tests_run++;
        if ({b_rvalid0, b_rvalid1, b_rdata0} !== {2'b10, 8'h5A})
            begin tests_failed++; $display("[TB] FAIL lat3_return: got %h required %h", {b_rvalid0, b_rvalid1, b_rdata0}, {2'b10, 8'h5A}); end
        tick();
        tests_run++;
        if ({b_rvalid0, b_rdata0} !== {1'b0, 8'h5A})
            begin tests_failed++; $display("[TB] FAIL lat3_hold: got %h required %h", {b_rvalid0, b_rdata0}, {1'b0, 8'h5A}); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = '0; b_wdata1 = '0;
        #3;
        test_reset();
        test_write_read_r0();
        test_cross_requester();
        test_simultaneous();
        test_read_interleave();
        test_reset_mid_read();
        test_rd_lat3();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
